rtc_escritura_ctrl: RTL and testbench
=====================================

// Module: rtc_escritura_ctrl
// PURPOSE
//  Write-cycle engine for the multiplexed address/data RTC bus (A_D, CS, RD, WR, active-low strobes).
//  Counterpart of the seconds-read path: takes a register address and a data byte from the PicoBlaze
//  output registers and runs one complete write transaction on the bus, then pulses listo.
//  Sits between the PicoBlaze output-port registers and the RTC bus mux.
// PARAMETERS
//  T_SETUP  1  cycles CS low, WR high, bus driven, before the strobe (>=1)
//  T_PULSE  4  cycles WR low per phase (>=1)
//  T_HOLD   1  cycles CS low, WR high, bus still driven, after the strobe (>=1)
//  T_GAP    2  cycles CS high, bus released, between the address and data phases (>=1)
//  CW       4  phase-counter width; must hold max(T_*)-1
// PORTS
//  clk      in   1  system clock
//  reset    in   1  synchronous, active-high reset
//  iniciar  in   1  start request; honoured only while idle
//  dir      in   8  RTC register address; captured on acceptance
//  dato     in   8  data to write; captured on acceptance
//  RTC_out  in   8  bus read-back; used only with RTC_WR_VERIFY_EN
//  RTC_in   out  8  value driven onto the bus
//  bus_oe   out  1  1 = drive RTC_in onto the bus
//  A_D      out  1  0 = address phase, 1 = data phase or idle
//  CS       out  1  chip select, active low
//  RD       out  1  read strobe, active low
//  WR       out  1  write strobe, active low
//  ocupado  out  1  transaction in progress
//  listo    out  1  one-cycle completion pulse
//  err_verif out 1  sticky read-back mismatch flag
// BEHAVIOUR
//  - All outputs are registered, or decoded from the registered state only. No input->output combinational path.
//  - Reset/idle values: A_D=1, CS=1, RD=1, WR=1, bus_oe=0, RTC_in=0, ocupado=0, listo=0, err_verif=0.
//  - Synchronous reset mid-transaction: state returns to IDLE and every output returns to its idle value
//    at that same edge. No partial strobe is ever completed.
//  - FSM: IDLE -> A_SET -> A_STB -> A_HLD -> GAP -> D_SET -> D_STB -> D_HLD -> DONE -> IDLE.
//    Each timed state lasts exactly its T_* value, counted by the phase counter (reloaded on every state entry).
//  - IDLE + iniciar=1: capture dir/dato, enter A_SET; ocupado=1 from the next cycle.
//    iniciar in any other state, including DONE, is ignored (no queueing).
//  - A_* states: A_D=0, RTC_in=dir, bus_oe=1, CS=0. WR=0 only in A_STB.
//  - GAP: CS=1, WR=1, bus_oe=0, A_D=1.
//  - D_* states: A_D=1, RTC_in=dato, bus_oe=1, CS=0. WR=0 only in D_STB.
//  - DONE: strobes at idle levels, listo=1 for exactly 1 cycle, ocupado=0 in the following cycle.
//  - RD stays 1 in every state unless RTC_WR_VERIFY_EN is defined.
//  - Default timing, cycle 0 = first A_SET cycle: WR low 1-4 and 9-12; CS high 6-7; listo at cycle 14.
//  - Changes on dir/dato while ocupado=1 have no effect on the transaction in progress.
// CONFIGURATION
//  RTC_WR_VERIFY_EN defined:
//  - DONE is replaced by a read-back sequence on the same address:
//    GAP2 -> RA_SET/RA_STB/RA_HLD (address phase again) -> GAP3 -> R_SET -> R_STB -> R_HLD -> DONE.
//  - R_* states: A_D=1, bus_oe=0, CS=0. RD=0 only in R_STB.
//  - RTC_out is sampled on the last R_STB cycle. A mismatch with the captured dato sets err_verif.
//  - err_verif is sticky; it clears on reset or on the next accepted iniciar.
//  - Default timing: listo at cycle 30.
//  RTC_WR_VERIFY_EN not defined: no read states, err_verif tied to 0, RTC_out unused.
// STRUCTURE
//  - Shared include rtc_bus_defs.vh holds: state encodings, the idle bus levels
//    (CS_INACT, WR_INACT, RD_INACT, AD_DATA), and the default T_* values.
//    The seconds-read path uses the same include.
//  - One sub-module, rtc_fase_timer: CW-bit down-counter with load/expire, one instance.
//  - Remaining logic (FSM, capture registers, output decode) stays in this module.
// TESTING
//  1. Reset, then idle for 10 cycles -> CS=WR=RD=A_D=1, bus_oe=0, listo=0 throughout.
//  2. iniciar with dir=8'h00, dato=8'h45 -> RTC_in=00, A_D=0 while WR low in cycles 1-4; RTC_in=45, A_D=1
//     while WR low in cycles 9-12; CS high in cycles 6-7; single listo at cycle 14.
//  3. iniciar held high for 40 cycles with dir=8'h02, dato=8'h12 -> back-to-back transactions,
//     each listo 15 cycles after acceptance, no overlapping CS.
//  4. Change dir/dato to 8'hFF during A_STB -> bus still carries the originally captured 00/45.
//  5. reset asserted during D_STB -> next cycle WR=1, CS=1, bus_oe=0, no listo; a new iniciar then runs normally.
//  6. VERIFY_EN: bus model returns 8'h44 for dato=8'h45 -> err_verif=1 at cycle 30 and held;
//     next correct write -> err_verif=0.

Source files
------------

// File: rtl/rtc_escritura_ctrl_pkg.sv
// Shared RTC bus definitions: FSM state encodings, idle bus levels and default phase timing.
// Also used by the seconds-read path so both engines agree on bus idle levels.
package rtc_escritura_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_GAP,
    S_D_SET, S_D_STB, S_D_HLD,
    S_GAP2, S_RA_SET, S_RA_STB, S_RA_HLD, S_GAP3,
    S_R_SET, S_R_STB, S_R_HLD,
    S_DONE
  } estado_e;

  localparam logic CS_INACT = 1'b1;
  localparam logic WR_INACT = 1'b1;
  localparam logic RD_INACT = 1'b1;
  localparam logic AD_DATA  = 1'b1;

  localparam int T_SETUP_DEF = 1;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF  = 1;
  localparam int T_GAP_DEF   = 2;
  localparam int CW_DEF      = 4;

endpackage

// File: rtl/rtc_fase_timer.sv
// Phase timer: CW-bit down-counter, loaded on every FSM state entry; expira when it reaches zero.
module rtc_fase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic [CW-1:0] valor,
  output logic          expira
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carga)
      cnt_d = valor;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expira = (cnt_q == '0);

endmodule

// File: rtl/rtc_escritura_ctrl.sv
// Write-cycle engine for the multiplexed A/D RTC bus: address phase, gap, data phase, listo pulse.
// Optional read-back check of the written byte when RTC_WR_VERIFY_EN is defined.
module rtc_escritura_ctrl
  import rtc_escritura_ctrl_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic [7:0] RTC_out,
  output logic [7:0] RTC_in,
  output logic       bus_oe,
  output logic       A_D,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       ocupado,
  output logic       listo,
  output logic       err_verif
);

  estado_e       state_q, state_d;
  logic [7:0]    dir_q, dir_d, dato_q, dato_d;
  logic          carga, expira, acepta;
  logic [CW-1:0] valor;

  function automatic logic [CW-1:0] duracion(estado_e s);
    case (s)
      S_A_SET, S_D_SET, S_RA_SET, S_R_SET: duracion = CW'(T_SETUP - 1);
      S_A_STB, S_D_STB, S_RA_STB, S_R_STB: duracion = CW'(T_PULSE - 1);
      S_A_HLD, S_D_HLD, S_RA_HLD, S_R_HLD: duracion = CW'(T_HOLD - 1);
      S_GAP, S_GAP2, S_GAP3:               duracion = CW'(T_GAP - 1);
      default:                             duracion = '0;
    endcase
  endfunction

  function automatic estado_e siguiente(estado_e s);
    case (s)
      S_A_SET:  siguiente = S_A_STB;
      S_A_STB:  siguiente = S_A_HLD;
      S_A_HLD:  siguiente = S_GAP;
      S_GAP:    siguiente = S_D_SET;
      S_D_SET:  siguiente = S_D_STB;
      S_D_STB:  siguiente = S_D_HLD;
`ifdef RTC_WR_VERIFY_EN
      S_D_HLD:  siguiente = S_GAP2;
`else
      S_D_HLD:  siguiente = S_DONE;
`endif
      S_GAP2:   siguiente = S_RA_SET;
      S_RA_SET: siguiente = S_RA_STB;
      S_RA_STB: siguiente = S_RA_HLD;
      S_RA_HLD: siguiente = S_GAP3;
      S_GAP3:   siguiente = S_R_SET;
      S_R_SET:  siguiente = S_R_STB;
      S_R_STB:  siguiente = S_R_HLD;
      S_R_HLD:  siguiente = S_DONE;
      default:  siguiente = S_IDLE;
    endcase
  endfunction

  assign acepta = (state_q == S_IDLE) && iniciar;

  // Next state; the timer is reloaded whenever the state changes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iniciar) state_d = S_A_SET;
      S_DONE:  state_d = S_IDLE;
      default: if (expira) state_d = siguiente(state_q);
    endcase
    carga = (state_d != state_q);
    valor = duracion(state_d);
    dir_d  = acepta ? dir  : dir_q;
    dato_d = acepta ? dato : dato_q;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    dir_q  <= dir_d;
    dato_q <= dato_d;
  end

  rtc_fase_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .carga  (carga),
    .valor  (valor),
    .expira (expira)
  );

  // Bus decode purely from the registered state, so reset idles the bus at the same edge.
  always_comb begin
    A_D     = AD_DATA;
    CS      = CS_INACT;
    RD      = RD_INACT;
    WR      = WR_INACT;
    bus_oe  = 1'b0;
    RTC_in  = 8'h00;
    ocupado = (state_q != S_IDLE);
    listo   = (state_q == S_DONE);
    case (state_q)
      S_A_SET, S_A_STB, S_A_HLD, S_RA_SET, S_RA_STB, S_RA_HLD: begin
        A_D    = 1'b0;
        CS     = 1'b0;
        bus_oe = 1'b1;
        RTC_in = dir_q;
        WR     = !(state_q == S_A_STB || state_q == S_RA_STB);
      end
      S_D_SET, S_D_STB, S_D_HLD: begin
        CS     = 1'b0;
        bus_oe = 1'b1;
        RTC_in = dato_q;
        WR     = (state_q != S_D_STB);
      end
      S_R_SET, S_R_STB, S_R_HLD: begin
        CS = 1'b0;
        RD = (state_q != S_R_STB);
      end
      default: ;
    endcase
  end

`ifdef RTC_WR_VERIFY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (acepta)
      err_d = 1'b0;
    else if (state_q == S_R_STB && expira && RTC_out != dato_q)
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_verif = err_q;
`else
  logic unused_rtc_out;
  assign unused_rtc_out = ^RTC_out;
  assign err_verif      = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_escritura_ctrl.sv
// Directed bench for rtc_escritura_ctrl; build with +define+RTC_WR_VERIFY_EN to cover the read-back path.
module tb_rtc_escritura_ctrl;

`ifdef RTC_WR_VERIFY_EN
  localparam int LISTO_C = 30;
`else
  localparam int LISTO_C = 14;
`endif
  localparam int PER = LISTO_C + 2;

  logic       clk = 1'b0;
  logic       reset, iniciar;
  logic [7:0] dir, dato, RTC_out;
  logic [7:0] RTC_in;
  logic       bus_oe, A_D, CS, RD, WR, ocupado, listo, err_verif;

  int vectors = 0;
  int miscompares = 0;

  rtc_escritura_ctrl dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .dir(dir), .dato(dato),
    .RTC_out(RTC_out), .RTC_in(RTC_in), .bus_oe(bus_oe), .A_D(A_D),
    .CS(CS), .RD(RD), .WR(WR), .ocupado(ocupado), .listo(listo),
    .err_verif(err_verif)
  );

  always #5 clk = ~clk;

  // {RTC_in, A_D, CS, RD, WR, bus_oe, ocupado, listo, err_verif}
  function automatic logic [15:0] obs();
    return {RTC_in, A_D, CS, RD, WR, bus_oe, ocupado, listo, err_verif};
  endfunction

  // Expected bus word c cycles after the first A_SET cycle (cycles past listo are idle).
  function automatic logic [15:0] exp_word(int c, logic [7:0] d, logic [7:0] v, logic bad);
    logic       ad = 1'b1, cs = 1'b1, rd = 1'b1, wr = 1'b1, oe = 1'b0, er = 1'b0;
    logic       oc, li;
    logic [7:0] bus = 8'h00;
    oc = (c <= LISTO_C);
    li = (c == LISTO_C);
    if (c <= 5) begin
      ad = 1'b0; cs = 1'b0; oe = 1'b1; bus = d; wr = !(c >= 1 && c <= 4);
    end else if (c >= 8 && c <= 13) begin
      cs = 1'b0; oe = 1'b1; bus = v; wr = !(c >= 9 && c <= 12);
    end
`ifdef RTC_WR_VERIFY_EN
    else if (c >= 16 && c <= 21) begin
      ad = 1'b0; cs = 1'b0; oe = 1'b1; bus = d; wr = !(c >= 17 && c <= 20);
    end else if (c >= 24 && c <= 29) begin
      cs = 1'b0; rd = !(c >= 25 && c <= 28);
    end
    er = bad && (c >= 29);
`else
    er = bad & 1'b0;
`endif
    return {bus, ad, cs, rd, wr, oe, oc, li, er};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One transaction; optionally corrupt dir/dato at cycle chg_at or assert reset at cycle rst_at.
  task automatic run_txn(input string tag, input logic [7:0] d, input logic [7:0] v,
                         input logic bad, input int chg_at, input int rst_at);
    dir = d; dato = v; iniciar = 1'b1;
    RTC_out = bad ? (v ^ 8'h01) : v;
    tick();
    iniciar = 1'b0;
    for (int c = 0; c <= LISTO_C + 1; c++) begin
      chk($sformatf("%s_c%0d", tag, c), obs(), exp_word(c, d, v, bad));
      if (c == chg_at) begin dir = 8'hFF; dato = 8'hFF; end
      if (c == rst_at) begin
        reset = 1'b1;
        tick();
        chk($sformatf("%s_rst", tag), obs(), {8'h00, 8'b1111_0000});
        reset = 1'b0;
        return;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; dir = 8'h00; dato = 8'h00; RTC_out = 8'h00;
    tick(); tick();
    chk("reset", obs(), {8'h00, 8'b1111_0000});
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle%0d", i), obs(), {8'h00, 8'b1111_0000});
    end

    // 2: basic write 00/45
    run_txn("wr45", 8'h00, 8'h45, 1'b0, -1, -1);

    // 3: iniciar held high -> back-to-back transactions, listo every PER cycles
    dir = 8'h02; dato = 8'h12; RTC_out = 8'h12; iniciar = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("b2b_k%0d", k), obs(), exp_word(k % PER, 8'h02, 8'h12, 1'b0));
      tick();
    end
    iniciar = 1'b0;
    for (int c = 40 % PER; c < PER; c++) begin
      chk($sformatf("b2b_tail%0d", c), obs(), exp_word(c, 8'h02, 8'h12, 1'b0));
      tick();
    end

    // 4: inputs change during A_STB, bus keeps captured values
    run_txn("chg", 8'h00, 8'h45, 1'b0, 2, -1);
    dir = 8'h00; dato = 8'h00;

    // 5: reset during D_STB, then a clean transaction
    run_txn("rstD", 8'h00, 8'h45, 1'b0, -1, 10);
    tick();
    chk("post_rst_idle", obs(), {8'h00, 8'b1111_0000});
    run_txn("after_rst", 8'h05, 8'h5A, 1'b0, -1, -1);

`ifdef RTC_WR_VERIFY_EN
    // 6: read-back returns 44 for 45 -> sticky error, cleared by the next good write
    run_txn("vbad", 8'h00, 8'h45, 1'b1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("vhold%0d", i), obs(), {8'h00, 8'b1111_0001});
    end
    run_txn("vgood", 8'h00, 8'h45, 1'b0, -1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
